// File: rtl/mmio_initiator_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mmio_initiator_pkg
// Description : Shared definitions for the peripheral register bank and the
//               bus between initiator and responder: register addresses,
//               bus mode encodings and the request address check.
// Ports       : none (package)
// Revision    : 1.0 - initial release
// ============================================================================
package mmio_initiator_pkg;

  localparam logic [31:0] PERIPH_ADDR_DISPLAY_CONTROL = 32'h20;
  localparam logic [31:0] PERIPH_ADDR_SEVENSEG_LO     = 32'h21;
  localparam logic [31:0] PERIPH_ADDR_SEVENSEG_HI     = 32'h22;
  localparam logic [31:0] PERIPH_ADDR_MONO_LED        = 32'h23;
  localparam logic [31:0] PERIPH_ADDR_COLOR_LED0      = 32'h24;
  localparam logic [31:0] PERIPH_ADDR_COLOR_LED1      = 32'h25;
  localparam logic [31:0] PERIPH_ADDR_STATUS          = 32'h26;

  localparam logic BUS_WRITE = 1'b1;
  localparam logic BUS_READ  = 1'b0;

  // A request is legal when it lands inside the bank and is not a write to
  // the read-only top word (status).
  function automatic logic addr_ok(input logic [31:0] addr,
                                   input logic        write,
                                   input logic [31:0] lo,
                                   input logic [31:0] hi);
    return (addr >= lo) && (addr <= hi) && !(write && (addr == hi));
  endfunction

endpackage
`default_nettype wire

// File: rtl/mmio_poll_timer.sv
`default_nettype none
// ============================================================================
// Module      : mmio_poll_timer
// Description : Free-running down-counter that raises a sticky poll request
//               every POLL_INTERVAL cycles. POLL_INTERVAL = 0 makes it inert.
// Ports       : clock        - system clock
//               reset        - synchronous active-high reset
//               clear        - drops the pending poll request
//               poll_pending - a status poll is owed
// Revision    : 1.0 - initial release
// ============================================================================
module mmio_poll_timer #(
  parameter int POLL_INTERVAL = 1000
) (
  input  logic clock,
  input  logic reset,
  input  logic clear,
  output logic poll_pending
);

  generate
    if (POLL_INTERVAL == 0) begin : g_poll_off
      logic w_unused;
      assign w_unused     = &{1'b0, clock, reset, clear};
      assign poll_pending = 1'b0;
    end else begin : g_poll_on
      localparam int CW = (POLL_INTERVAL < 2) ? 1 : $clog2(POLL_INTERVAL + 1);
      localparam logic [CW-1:0] RELOAD = CW'(POLL_INTERVAL - 1);

      logic [CW-1:0] r_count;
      logic          r_pending;

      // An expiry wins over a same-cycle clear so no interval is lost; an
      // expiry while already pending simply merges into the existing flag.
      always_ff @(posedge clock) begin
        if (reset) begin
          r_count   <= RELOAD;
          r_pending <= 1'b0;
        end else if (r_count == '0) begin
          r_count   <= RELOAD;
          r_pending <= 1'b1;
        end else begin
          r_count <= r_count - CW'(1);
          if (clear) begin
            r_pending <= 1'b0;
          end
        end
      end

      assign poll_pending = r_pending;
    end
  endgenerate

endmodule
`default_nettype wire

// File: rtl/mmio_initiator.sv
`default_nettype none
// ============================================================================
// Module      : mmio_initiator
// Description : Single-outstanding bus initiator for the peripheral bank.
//               Turns valid/ready requests into one-cycle bus accesses,
//               returns responses on a valid/ready channel and periodically
//               polls the status word, flagging changes.
// Ports       : clock, reset            - clock / sync active-high reset
//               req_*                   - request channel (valid/ready)
//               rsp_*                   - response channel (valid/ready)
//               bus_address/mode/wdata  - registered bus to responder
//               bus_rdata               - responder read data (combinational)
//               status_last             - last polled status word
//               status_changed          - one-cycle pulse on status change
// Revision    : 1.0 - initial release
// ============================================================================
module mmio_initiator
  import mmio_initiator_pkg::*;
#(
  parameter int          POLL_INTERVAL = 1000,
  parameter logic [31:0] ADDR_LO       = 32'h20,
  parameter logic [31:0] ADDR_HI       = 32'h26
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic [31:0] bus_address,
  output logic        bus_mode,
  output logic [31:0] bus_wdata,
  input  logic [31:0] bus_rdata,
  output logic [31:0] status_last,
  output logic        status_changed
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACCESS = 2'd1,
    S_RESP   = 2'd2,
    S_POLL   = 2'd3
  } state_t;

  state_t      r_state, w_state_next;
  logic [31:0] r_bus_address, w_bus_address;
  logic        r_bus_mode, w_bus_mode;
  logic [31:0] r_bus_wdata, w_bus_wdata;
  logic        r_rsp_valid, w_rsp_valid;
  logic [31:0] r_rsp_rdata, w_rsp_rdata;
  logic        r_rsp_err, w_rsp_err;
  logic [31:0] r_status_last, w_status_last;
  logic        r_status_changed, w_status_changed;
  logic        w_req_ready;
  logic        w_poll_pending;
  logic        w_poll_clear;

  mmio_poll_timer #(
    .POLL_INTERVAL(POLL_INTERVAL)
  ) u_poll_timer (
    .clock       (clock),
    .reset       (reset),
    .clear       (w_poll_clear),
    .poll_pending(w_poll_pending)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state          <= S_IDLE;
      r_bus_address    <= '0;
      r_bus_mode       <= BUS_READ;
      r_bus_wdata      <= '0;
      r_rsp_valid      <= 1'b0;
      r_rsp_rdata      <= '0;
      r_rsp_err        <= 1'b0;
      r_status_last    <= '0;
      r_status_changed <= 1'b0;
    end else begin
      r_state          <= w_state_next;
      r_bus_address    <= w_bus_address;
      r_bus_mode       <= w_bus_mode;
      r_bus_wdata      <= w_bus_wdata;
      r_rsp_valid      <= w_rsp_valid;
      r_rsp_rdata      <= w_rsp_rdata;
      r_rsp_err        <= w_rsp_err;
      r_status_last    <= w_status_last;
      r_status_changed <= w_status_changed;
    end
  end

  // The bus defaults to its idle value (read of address 0) every cycle and
  // is only loaded when entering ACCESS or POLL, so each access lasts
  // exactly one cycle.
  always_comb begin
    w_state_next     = r_state;
    w_bus_address    = '0;
    w_bus_mode       = BUS_READ;
    w_bus_wdata      = '0;
    w_rsp_valid      = r_rsp_valid;
    w_rsp_rdata      = r_rsp_rdata;
    w_rsp_err        = r_rsp_err;
    w_status_last    = r_status_last;
    w_status_changed = 1'b0;
    w_poll_clear     = 1'b0;
    w_req_ready      = 1'b0;

    case (r_state)
      S_IDLE: begin
        w_req_ready = !w_poll_pending;
        if (w_poll_pending) begin
          w_bus_address = ADDR_HI;
          w_state_next  = S_POLL;
        end else if (req_valid) begin
          if (addr_ok(req_addr, req_write, ADDR_LO, ADDR_HI)) begin
            w_bus_address = req_addr;
            w_bus_mode    = req_write;
            w_bus_wdata   = req_wdata;
            w_state_next  = S_ACCESS;
          end else begin
            // Rejected requests never touch the bus.
            w_rsp_valid  = 1'b1;
            w_rsp_err    = 1'b1;
            w_rsp_rdata  = '0;
            w_state_next = S_RESP;
          end
        end
      end
      S_ACCESS: begin
        w_rsp_valid  = 1'b1;
        w_rsp_err    = 1'b0;
        w_rsp_rdata  = (r_bus_mode == BUS_WRITE) ? 32'h0 : bus_rdata;
        w_state_next = S_RESP;
      end
      S_RESP: begin
        if (rsp_ready) begin
          w_rsp_valid  = 1'b0;
          w_rsp_err    = 1'b0;
          w_rsp_rdata  = '0;
          w_state_next = S_IDLE;
        end
      end
      S_POLL: begin
        w_poll_clear = 1'b1;
        if (bus_rdata != r_status_last) begin
          w_status_last    = bus_rdata;
          w_status_changed = 1'b1;
        end
        w_state_next = S_IDLE;
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  assign req_ready      = w_req_ready;
  assign rsp_valid      = r_rsp_valid;
  assign rsp_rdata      = r_rsp_rdata;
  assign rsp_err        = r_rsp_err;
  assign bus_address    = r_bus_address;
  assign bus_mode       = r_bus_mode;
  assign bus_wdata      = r_bus_wdata;
  assign status_last    = r_status_last;
  assign status_changed = r_status_changed;

endmodule
`default_nettype wire

// File: tb/tb_mmio_initiator.sv
`default_nettype none
// ============================================================================
// Module      : tb_mmio_initiator
// Description : Directed self-checking bench. Instance A has polling off and
//               exercises the request path; instance B polls every 8 cycles.
//               Each instance talks to a small behavioural responder.
// Ports       : none
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mmio_initiator;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  int n_checks = 0;
  int n_errors = 0;

  // ---------------- instance A (no polling) ----------------
  logic        reset_a = 1'b1;
  logic        req_valid_a = 1'b0, req_ready_a, req_write_a = 1'b0;
  logic [31:0] req_addr_a = '0, req_wdata_a = '0;
  logic        rsp_valid_a, rsp_ready_a = 1'b1, rsp_err_a;
  logic [31:0] rsp_rdata_a, bus_address_a, bus_wdata_a, bus_rdata_a;
  logic        bus_mode_a;
  logic [31:0] status_last_a;
  logic        status_changed_a;
  logic [31:0] status_a = '0;
  logic [31:0] regs_a [0:7];

  mmio_initiator #(.POLL_INTERVAL(0)) dut_a (
    .clock(clock), .reset(reset_a),
    .req_valid(req_valid_a), .req_ready(req_ready_a), .req_write(req_write_a),
    .req_addr(req_addr_a), .req_wdata(req_wdata_a),
    .rsp_valid(rsp_valid_a), .rsp_ready(rsp_ready_a),
    .rsp_rdata(rsp_rdata_a), .rsp_err(rsp_err_a),
    .bus_address(bus_address_a), .bus_mode(bus_mode_a),
    .bus_wdata(bus_wdata_a), .bus_rdata(bus_rdata_a),
    .status_last(status_last_a), .status_changed(status_changed_a)
  );

  // Responder A: registers 0x20..0x25 writable, 0x26 is status; no reset so
  // a write in flight at a reset edge still lands.
  initial for (int i = 0; i < 8; i++) regs_a[i] = '0;
  always @(posedge clock)
    if (bus_mode_a && bus_address_a >= 32'h20 && bus_address_a <= 32'h25)
      regs_a[bus_address_a[2:0]] <= bus_wdata_a;
  always_comb begin
    bus_rdata_a = '0;
    if (bus_address_a >= 32'h20 && bus_address_a <= 32'h25)
      bus_rdata_a = regs_a[bus_address_a[2:0]];
    else if (bus_address_a == 32'h26)
      bus_rdata_a = status_a;
  end

  // ---------------- instance B (poll every 8) ----------------
  logic        reset_b = 1'b1;
  logic        req_valid_b = 1'b0, req_ready_b;
  logic        rsp_valid_b, rsp_err_b;
  logic [31:0] rsp_rdata_b, bus_address_b, bus_wdata_b, bus_rdata_b;
  logic        bus_mode_b;
  logic [31:0] status_last_b;
  logic        status_changed_b;
  logic [31:0] status_b = '0;

  mmio_initiator #(.POLL_INTERVAL(8)) dut_b (
    .clock(clock), .reset(reset_b),
    .req_valid(req_valid_b), .req_ready(req_ready_b), .req_write(1'b0),
    .req_addr(32'h20), .req_wdata(32'h0),
    .rsp_valid(rsp_valid_b), .rsp_ready(1'b1),
    .rsp_rdata(rsp_rdata_b), .rsp_err(rsp_err_b),
    .bus_address(bus_address_b), .bus_mode(bus_mode_b),
    .bus_wdata(bus_wdata_b), .bus_rdata(bus_rdata_b),
    .status_last(status_last_b), .status_changed(status_changed_b)
  );

  assign bus_rdata_b = (bus_address_b == 32'h26) ? status_b : 32'h0;

  // ---------------- helpers ----------------
  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Presents a request, waits for the handshake edge and withdraws it.
  // Returns one cycle after the accepting cycle.
  task automatic req_a(input logic wr, input logic [31:0] addr,
                       input logic [31:0] wd);
    int n;
    n = 0;
    req_valid_a = 1'b1; req_write_a = wr; req_addr_a = addr; req_wdata_a = wd;
    while (!req_ready_a && n < 20) begin
      tick();
      n++;
    end
    if (!req_ready_a) check("req_a_ready_timeout", 32'd0, 32'd1);
    tick();
    req_valid_a = 1'b0; req_write_a = 1'b0; req_addr_a = '0; req_wdata_a = '0;
  endtask

  int pulses, polls, bad_mode, accepts;

  initial begin
    tick(); tick();
    reset_a = 1'b0;
    reset_b = 1'b0;
    // Reset state (still in the first cycle after release, nothing driven).
    check("rst_rsp_valid", {31'b0, rsp_valid_a}, 32'd0);
    check("rst_bus_mode", {31'b0, bus_mode_a}, 32'd0);
    check("rst_bus_address", bus_address_a, 32'h0);
    check("rst_req_ready", {31'b0, req_ready_a}, 32'd1);

    // Write 0x23 <= 0xA5
    rsp_ready_a = 1'b1;
    req_a(1'b1, 32'h23, 32'h0000_00A5);
    check("wr_bus_mode_on", {31'b0, bus_mode_a}, 32'd1);
    check("wr_bus_address", bus_address_a, 32'h23);
    check("wr_bus_wdata", bus_wdata_a, 32'hA5);
    check("wr_rsp_early", {31'b0, rsp_valid_a}, 32'd0);
    tick();
    check("wr_bus_mode_off", {31'b0, bus_mode_a}, 32'd0);
    check("wr_rsp_valid", {31'b0, rsp_valid_a}, 32'd1);
    check("wr_rsp_err", {31'b0, rsp_err_a}, 32'd0);
    check("wr_rsp_rdata", rsp_rdata_a, 32'h0);
    check("wr_mono_led", regs_a[3], 32'hA5);
    tick();
    check("wr_rsp_cleared", {31'b0, rsp_valid_a}, 32'd0);
    check("wr_ready_again", {31'b0, req_ready_a}, 32'd1);

    // Write then read back 0x24 with the consumer stalling
    req_a(1'b1, 32'h24, 32'h00FF_0000);
    tick(); tick();
    rsp_ready_a = 1'b0;
    req_a(1'b0, 32'h24, 32'h0);
    tick();
    check("rd_rsp_valid", {31'b0, rsp_valid_a}, 32'd1);
    check("rd_rsp_rdata", rsp_rdata_a, 32'h00FF_0000);
    for (int i = 0; i < 5; i++) begin
      tick();
      check("stall_valid", {31'b0, rsp_valid_a}, 32'd1);
      check("stall_rdata", rsp_rdata_a, 32'h00FF_0000);
      check("stall_req_ready", {31'b0, req_ready_a}, 32'd0);
    end
    rsp_ready_a = 1'b1;
    tick();
    check("stall_release_valid", {31'b0, rsp_valid_a}, 32'd0);
    check("stall_release_ready", {31'b0, req_ready_a}, 32'd1);
    check("stall_release_rdata", rsp_rdata_a, 32'h0);

    // Out-of-range read, write to status, below-range read
    req_a(1'b0, 32'h30, 32'h0);
    check("oor_rsp_valid", {31'b0, rsp_valid_a}, 32'd1);
    check("oor_rsp_err", {31'b0, rsp_err_a}, 32'd1);
    check("oor_rsp_rdata", rsp_rdata_a, 32'h0);
    check("oor_bus_mode", {31'b0, bus_mode_a}, 32'd0);
    tick();
    req_a(1'b1, 32'h26, 32'h1234);
    check("wrst_rsp_err", {31'b0, rsp_err_a}, 32'd1);
    check("wrst_rsp_valid", {31'b0, rsp_valid_a}, 32'd1);
    check("wrst_bus_mode", {31'b0, bus_mode_a}, 32'd0);
    check("wrst_bus_address", bus_address_a, 32'h0);
    tick();
    check("regs_keep_23", regs_a[3], 32'hA5);
    check("regs_keep_24", regs_a[4], 32'h00FF_0000);
    req_a(1'b0, 32'h1F, 32'h0);
    check("below_rsp_err", {31'b0, rsp_err_a}, 32'd1);
    tick();

    // Legal read of the top address (status)
    status_a = 32'h77;
    req_a(1'b0, 32'h26, 32'h0);
    tick();
    check("rdst_rsp_rdata", rsp_rdata_a, 32'h77);
    check("rdst_rsp_err", {31'b0, rsp_err_a}, 32'd0);
    tick();

    // Reset during a write's ACCESS cycle
    req_a(1'b1, 32'h21, 32'hBEEF);
    reset_a = 1'b1;
    tick();
    check("mid_rst_commit", regs_a[1], 32'hBEEF);
    check("mid_rst_rsp_valid", {31'b0, rsp_valid_a}, 32'd0);
    check("mid_rst_bus_mode", {31'b0, bus_mode_a}, 32'd0);
    check("mid_rst_bus_address", bus_address_a, 32'h0);
    reset_a = 1'b0;
    tick();
    check("post_rst_rsp_valid", {31'b0, rsp_valid_a}, 32'd0);
    check("no_poll_status_last", status_last_a, 32'h0);

    // Polling on B: first poll 9 cycles after reset release, period 8
    reset_b = 1'b1;
    tick(); tick();
    reset_b = 1'b0;
    pulses = 0; polls = 0; bad_mode = 0;
    for (int i = 1; i <= 12; i++) begin
      tick();
      if (status_changed_b) pulses++;
      if (bus_address_b == 32'h26) begin
        polls++;
        if (bus_mode_b) bad_mode++;
      end
    end
    check("poll_same_pulses", pulses, 32'd0);
    check("poll_first_count", polls, 32'd1);
    status_b = 32'h5;
    pulses = 0; polls = 0;
    for (int i = 13; i <= 36; i++) begin
      tick();
      if (status_changed_b) pulses++;
      if (bus_address_b == 32'h26) begin
        polls++;
        if (bus_mode_b) bad_mode++;
      end
    end
    check("poll_change_pulses", pulses, 32'd1);
    check("poll_change_count", polls, 32'd3);
    check("poll_status_last", status_last_b, 32'h5);
    check("poll_bus_mode", bad_mode, 32'd0);

    // Continuous requests still leave room for a poll every 8 cycles
    req_valid_b = 1'b1;
    polls = 0; accepts = 0;
    for (int i = 0; i < 80; i++) begin
      if (req_ready_b) accepts++;
      tick();
      if (bus_address_b == 32'h26) polls++;
    end
    req_valid_b = 1'b0;
    check("load_poll_rate", {31'b0, (polls >= 9 && polls <= 11)}, 32'd1);
    check("load_accepts", {31'b0, (accepts >= 15)}, 32'd1);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
